// File: rtl/cmd_frame_pkg.sv
// cmd_frame_pkg: opcodes, command encodings, byte counts and FSM states for the command framer
package cmd_frame_pkg;
  typedef enum logic [1:0] {CMD_RF_WR = 2'd0, CMD_RF_RD = 2'd1, CMD_ALU_OP = 2'd2, CMD_ALU_NOP = 2'd3} cmd_type_t;
  localparam logic [7:0] OP_RF_WR = 8'hAA;
  localparam logic [7:0] OP_RF_RD = 8'hBB;
  localparam logic [7:0] OP_ALU_OP = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;
  typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_PARITY, B_STOP} bit_state_t;
  typedef enum logic [1:0] {F_IDLE, F_SEND, F_GAP} frame_state_t;
  function automatic logic [7:0] opcode(input logic [1:0] t);
    return t == CMD_RF_WR ? OP_RF_WR : t == CMD_RF_RD ? OP_RF_RD : t == CMD_ALU_OP ? OP_ALU_OP : OP_ALU_NOP;
  endfunction
  function automatic logic [2:0] byte_count(input logic [1:0] t);
    return t == CMD_RF_WR ? 3'd3 : t == CMD_ALU_OP ? 3'd4 : 3'd2;
  endfunction
endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: serializes one byte (start, data LSB first, optional parity, stop) on a registered line
module uart_byte_tx
  import cmd_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      go,
  input  logic [DATA_WIDTH-1:0]     din,
  input  logic                      par_en,
  input  logic                      par_typ,
  input  logic [PRESCALE_WIDTH-1:0] p_last,
  output logic                      line,
  output logic                      byte_done
);
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  bit_state_t st, st_n;
  logic [PRESCALE_WIDTH-1:0] cnt, cnt_n;
  logic [BW-1:0] idx, idx_n;
  logic [DATA_WIDTH-1:0] data;
  logic tick, line_n;
  assign tick = cnt == p_last;
  assign byte_done = st == B_STOP && tick;
  always_comb begin
    st_n = st;
    idx_n = idx;
    cnt_n = (st == B_IDLE || tick) ? '0 : cnt + 1'b1;
    case (st)
      B_IDLE: st_n = go ? B_START : B_IDLE;
      B_START: if (tick) begin st_n = B_DATA; idx_n = '0; end
      B_DATA: if (tick) begin
        st_n = idx == BW'(DATA_WIDTH - 1) ? (par_en ? B_PARITY : B_STOP) : B_DATA;
        idx_n = idx + 1'b1;
      end
      B_PARITY: st_n = tick ? B_STOP : B_PARITY;
      default: st_n = tick ? (go ? B_START : B_IDLE) : B_STOP;
    endcase
    // line is registered, so it is driven from the state about to be entered
    line_n = st_n == B_START ? 1'b0 : st_n == B_DATA ? data[idx_n] : st_n == B_PARITY ? (^data ^ par_typ) : 1'b1;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st <= B_IDLE;
      cnt <= '0;
      idx <= '0;
      data <= '0;
      line <= 1'b1;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      idx <= idx_n;
      line <= line_n;
      if (go) data <= din;
    end
  end
endmodule

// File: rtl/cmd_frame_tx.sv
// cmd_frame_tx: sequences opcode and payload bytes of one command onto the UART line with idle gaps
module cmd_frame_tx
  import cmd_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_WIDTH = 5,
  parameter int GAP_BITS = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_type,
  input  logic [DATA_WIDTH-1:0]     cmd_b1,
  input  logic [DATA_WIDTH-1:0]     cmd_b2,
  input  logic [DATA_WIDTH-1:0]     cmd_b3,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      TX_LINE,
  output logic                      busy,
  output logic                      frame_done
);
  localparam int GW = GAP_BITS > 1 ? $clog2(GAP_BITS) : 1;
  frame_state_t st, st_n;
  logic [1:0] type_q, idx, idx_n;
  logic [DATA_WIDTH-1:0] b1_q, b2_q, b3_q, byte_n;
  logic par_en_q, par_typ_q;
  logic [PRESCALE_WIDTH-1:0] p_last_q, pcnt, pcnt_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic accept, go, byte_done, done_n, final_byte;
  assign cmd_ready = st == F_IDLE;
  assign busy = !cmd_ready;
  assign accept = cmd_valid && cmd_ready;
  assign final_byte = {1'b0, idx} == byte_count(type_q) - 3'd1;
  always_comb begin
    st_n = st;
    idx_n = idx;
    pcnt_n = '0;
    gcnt_n = gcnt;
    go = 1'b0;
    done_n = 1'b0;
    case (st)
      F_IDLE: if (accept) begin st_n = F_SEND; idx_n = '0; go = 1'b1; end
      F_SEND: if (byte_done) begin
        if (final_byte) begin st_n = F_IDLE; done_n = 1'b1; end
        else if (GAP_BITS == 0) begin idx_n = idx + 1'b1; go = 1'b1; end
        else begin st_n = F_GAP; gcnt_n = '0; end
      end
      default: if (pcnt == p_last_q) begin
        if (gcnt == GW'(GAP_BITS - 1)) begin st_n = F_SEND; idx_n = idx + 1'b1; go = 1'b1; end
        else gcnt_n = gcnt + 1'b1;
      end else pcnt_n = pcnt + 1'b1;
    endcase
    // the opcode of a freshly accepted command comes straight from the inputs
    byte_n = accept ? DATA_WIDTH'(opcode(cmd_type)) : idx_n == 2'd1 ? b1_q : idx_n == 2'd2 ? b2_q : b3_q;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st <= F_IDLE;
      idx <= '0;
      pcnt <= '0;
      gcnt <= '0;
      frame_done <= 1'b0;
      type_q <= '0;
      b1_q <= '0;
      b2_q <= '0;
      b3_q <= '0;
      par_en_q <= 1'b0;
      par_typ_q <= 1'b0;
      p_last_q <= '1;
    end else begin
      st <= st_n;
      idx <= idx_n;
      pcnt <= pcnt_n;
      gcnt <= gcnt_n;
      frame_done <= done_n;
      if (accept) begin
        type_q <= cmd_type;
        b1_q <= cmd_b1;
        b2_q <= cmd_b2;
        b3_q <= cmd_b3;
        par_en_q <= PAR_EN;
        par_typ_q <= PAR_TYP;
        p_last_q <= prescale - 1'b1;
      end
    end
  end
  uart_byte_tx #(.DATA_WIDTH(DATA_WIDTH), .PRESCALE_WIDTH(PRESCALE_WIDTH)) u_byte (
    .CLK(CLK),
    .RST(RST),
    .go(go),
    .din(byte_n),
    .par_en(par_en_q),
    .par_typ(par_typ_q),
    .p_last(p_last_q),
    .line(TX_LINE),
    .byte_done(byte_done)
  );
endmodule
